// File: rtl/mo_cart_pkg.sv
// Shared types and constants for the cartridge loader.
package mo_cart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } wr_state_t;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
   } cart_word_t;

   localparam logic [7:0]  PAD_BYTE          = 8'hFF;
   localparam logic [23:0] DEFAULT_CART_BASE = 24'h080000;

endpackage

// File: rtl/mo_cart_fifo.sv
// Small synchronous word FIFO between the byte packer and the SDRAM write FSM.
// DEPTH must be a power of two.
module mo_cart_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/mo_cart_loader.sv
// Packs cartridge bytes from data_io into 16-bit SDRAM word writes and tracks image status.
// Optional feature macro: MO_CART_CHECKSUM_EN adds a 16-bit byte-sum output port.
module mo_cart_loader
   import mo_cart_pkg::*;
#(
   parameter logic [23:0] CART_BASE      = DEFAULT_CART_BASE,
   parameter int          CART_MAX_BYTES = 65536,
   parameter int          FIFO_DEPTH     = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        eject,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic        mem_ack,
   output logic        cartridge_present,
   output logic [16:0] cart_size,
   output logic        busy,
   output logic        overflow
`ifdef MO_CART_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam logic [24:0] MAX_ADDR = 25'(CART_MAX_BYTES);

   logic        dl_q;
   logic        cart_wr;
   logic        in_range;
   logic        accept;
   logic        reject;
   logic        dl_start;
   logic        dl_end;
   logic        busy_done;
   logic [23:0] byte_addr;
   logic [16:0] size_base;
   logic [16:0] addr_next;
   logic        unused_index;

   logic [7:0]  pack_lo;
   logic        held;
   logic [23:0] held_addr;
   logic        push_valid;
   cart_word_t  push_word;

   cart_word_t  fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;

   wr_state_t   state;
   wr_state_t   state_next;

   assign unused_index = ^ioctl_index[7:1];

   assign cart_wr   = ioctl_wr && ioctl_download && ioctl_index[0];
   assign in_range  = (ioctl_addr < MAX_ADDR);
   assign accept    = cart_wr && in_range;
   assign reject    = cart_wr && !in_range;
   assign dl_start  = ioctl_download && !dl_q && ioctl_index[0];
   assign dl_end    = dl_q && !ioctl_download && busy;
   assign byte_addr = CART_BASE + {ioctl_addr[23:1], 1'b0};

   // Even bytes wait in pack_lo; an odd byte or the end of the download emits a word next cycle.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_q       <= 1'b0;
         pack_lo    <= '0;
         held       <= 1'b0;
         held_addr  <= '0;
         push_valid <= 1'b0;
         push_word  <= '0;
      end else begin
         dl_q       <= ioctl_download;
         push_valid <= 1'b0;
         if (dl_start) begin
            held <= 1'b0;
         end
         if (accept && !ioctl_addr[0]) begin
            pack_lo   <= ioctl_dout;
            held      <= 1'b1;
            held_addr <= byte_addr;
         end else if (accept && ioctl_addr[0]) begin
            push_valid <= 1'b1;
            push_word  <= '{addr: byte_addr, data: {ioctl_dout, pack_lo}};
            held       <= 1'b0;
         end else if (dl_end && held) begin
            push_valid <= 1'b1;
            push_word  <= '{addr: held_addr, data: {PAD_BYTE, pack_lo}};
            held       <= 1'b0;
         end
      end
   end

   mo_cart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cart_word_t))
   ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push    (push_valid),
      .pop     (fifo_pop),
      .din     (push_word),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifo_empty) state_next = REQ;
         REQ:     if (mem_ack)     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req  = (state == REQ);
      fifo_pop = (state == REQ) && mem_ack;
   end

   // Address and data are captured once on entry to REQ so they stay frozen until the ack.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (state == IDLE && !fifo_empty) begin
         mem_addr <= fifo_head.addr;
         mem_din  <= fifo_head.data;
      end
   end

   assign busy_done = busy && !ioctl_download && !held && !push_valid &&
                      fifo_empty && (state == IDLE);
   assign size_base = dl_start ? 17'd0 : cart_size;
   assign addr_next = ioctl_addr[16:0] + 17'd1;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         busy              <= 1'b0;
         cart_size         <= '0;
         overflow          <= 1'b0;
         cartridge_present <= 1'b0;
      end else begin
         busy      <= dl_start || (busy && !busy_done);
         cart_size <= (accept && (addr_next > size_base)) ? addr_next : size_base;
         overflow  <= (dl_start ? 1'b0 : overflow) | reject | (push_valid && fifo_full);
         if (eject || dl_start) begin
            cartridge_present <= 1'b0;
         end else if (busy_done && (cart_size != 17'd0)) begin
            cartridge_present <= 1'b1;
         end
      end
   end

`ifdef MO_CART_CHECKSUM_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         checksum <= '0;
      end else begin
         checksum <= (dl_start ? 16'h0000 : checksum) + (accept ? {8'h00, ioctl_dout} : 16'h0000);
      end
   end
`endif

endmodule

// File: tb/tb_mo_cart_loader.sv
// Self-checking bench for mo_cart_loader: table vectors, corner sequences and a randomized model check.
// Define MO_CART_CHECKSUM_EN to also exercise the checksum port.
`timescale 1ns/1ps
module tb_mo_cart_loader;

   localparam logic [23:0] BASE     = 24'h080000;
   localparam int          MAX_B    = 65536;
   localparam int          IDLE_LIM = 1000;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
   } byte_t;

   typedef struct {
      logic [7:0]       idx;
      int               nbytes;
      logic [3:0][7:0]  data;
      logic             do_eject;
      int               exp_nwr;
      logic [1:0][39:0] exp_wr;
      logic [16:0]      exp_size;
      logic             exp_present;
      logic             exp_overflow;
   } vec_t;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'h00;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'h00;
   logic        eject = 1'b0;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_ack = 1'b0;
   logic        cartridge_present;
   logic [16:0] cart_size;
   logic        busy;
   logic        overflow;
`ifdef MO_CART_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   int          n_vectors = 0;
   int          n_miscompares = 0;
   logic        ack_enable = 1'b1;
   int          ack_delay = 2;
   int          stable_err = 0;
   logic [39:0] writes [$];
   logic [39:0] exp_q [$];
   byte_t       stim_q [$];
   vec_t        vecs [6];

   mo_cart_loader dut (
      .clk_sys           (clk_sys),
      .reset             (reset),
      .ioctl_download    (ioctl_download),
      .ioctl_index       (ioctl_index),
      .ioctl_wr          (ioctl_wr),
      .ioctl_addr        (ioctl_addr),
      .ioctl_dout        (ioctl_dout),
      .eject             (eject),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_din           (mem_din),
      .mem_ack           (mem_ack),
      .cartridge_present (cartridge_present),
      .cart_size         (cart_size),
      .busy              (busy),
      .overflow          (overflow)
`ifdef MO_CART_CHECKSUM_EN
      ,
      .checksum          (checksum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   // SDRAM stand-in: acks after ack_delay cycles, logs writes, flags any drift while requesting.
   initial begin
      int          req_age;
      logic [23:0] req_addr0;
      logic [15:0] req_din0;
      req_age = 0;
      req_addr0 = '0;
      req_din0 = '0;
      forever begin
         @(negedge clk_sys);
         mem_ack = 1'b0;
         if (reset || !mem_req) begin
            req_age = 0;
         end else begin
            if (req_age == 0) begin
               req_addr0 = mem_addr;
               req_din0  = mem_din;
            end else if (mem_addr !== req_addr0 || mem_din !== req_din0) begin
               stable_err++;
            end
            req_age++;
            if (ack_enable && req_age > ack_delay) begin
               mem_ack = 1'b1;
               writes.push_back({mem_addr, mem_din});
               req_age = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] idx, input int gap);
      @(negedge clk_sys);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      repeat (2) @(negedge clk_sys);
      foreach (stim_q[i]) begin
         ioctl_addr = stim_q[i].addr;
         ioctl_dout = stim_q[i].data;
         ioctl_wr   = 1'b1;
         @(negedge clk_sys);
         ioctl_wr = 1'b0;
         repeat (gap) @(negedge clk_sys);
      end
      ioctl_download = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int cycles;
      cycles = 0;
      @(negedge clk_sys);
      while ((busy || mem_req) && cycles < IDLE_LIM) begin
         @(negedge clk_sys);
         cycles++;
      end
      checkOutput({name, " drain"}, 64'(cycles < IDLE_LIM), 64'd1);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic pushByte(input int addr, input logic [7:0] data);
      byte_t b;
      b.addr = 25'(addr);
      b.data = data;
      stim_q.push_back(b);
   endtask

   // Reference: accepted bytes pair up by address; a lone even byte gets the FF pad.
   task automatic buildModel(output logic [16:0] exp_size, output logic exp_ovf);
      byte_t acc [$];
      int    max_end;
      exp_q.delete();
      max_end = 0;
      exp_ovf = 1'b0;
      foreach (stim_q[i]) begin
         if (int'(stim_q[i].addr) < MAX_B) begin
            acc.push_back(stim_q[i]);
            if (int'(stim_q[i].addr) + 1 > max_end) max_end = int'(stim_q[i].addr) + 1;
         end else begin
            exp_ovf = 1'b1;
         end
      end
      for (int k = 0; k < acc.size(); k++) begin
         if (!acc[k].addr[0]) begin
            if (k + 1 < acc.size() && acc[k+1].addr == acc[k].addr + 25'd1) begin
               exp_q.push_back({BASE + acc[k].addr[23:0], acc[k+1].data, acc[k].data});
               k++;
            end else begin
               exp_q.push_back({BASE + acc[k].addr[23:0], 8'hFF, acc[k].data});
            end
         end
      end
      exp_size = 17'(max_end);
   endtask

   initial begin
      logic [16:0] m_size;
      logic        m_ovf;
      string       nm;

      vecs[0] = '{8'h01, 4, 32'h44332211, 1'b0, 2, {40'h080002_4433, 40'h080000_2211}, 17'd4, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 3, 32'h00CCBBAA, 1'b0, 2, {40'h080002_FFCC, 40'h080000_BBAA}, 17'd3, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1, 32'h0000005A, 1'b0, 1, {40'h0, 40'h080000_FF5A}, 17'd1, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 2, 32'h00003412, 1'b0, 0, {40'h0, 40'h0}, 17'd1, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 0, 32'h00000000, 1'b1, 0, {40'h0, 40'h0}, 17'd1, 1'b0, 1'b0};
      vecs[5] = '{8'h03, 2, 32'h00000201, 1'b0, 1, {40'h0, 40'h080000_0201}, 17'd2, 1'b1, 1'b0};

      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      checkOutput("reset mem_req", 64'(mem_req), 64'd0);
      checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset mem_din", 64'(mem_din), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset present", 64'(cartridge_present), 64'd0);
      checkOutput("reset size", 64'(cart_size), 64'd0);
      checkOutput("reset overflow", 64'(overflow), 64'd0);

      foreach (vecs[v]) begin
         stim_q.delete();
         for (int b = 0; b < vecs[v].nbytes; b++) pushByte(b, vecs[v].data[b]);
         ack_delay = 2;
         writes.delete();
         applyStimulus(vecs[v].idx, 2);
         nm = $sformatf("vec%0d", v);
         waitIdle(nm);
         if (vecs[v].do_eject) begin
            eject = 1'b1;
            @(negedge clk_sys);
            eject = 1'b0;
            @(negedge clk_sys);
         end
         checkOutput({nm, " write count"}, 64'(writes.size()), 64'(vecs[v].exp_nwr));
         for (int i = 0; i < vecs[v].exp_nwr; i++) begin
            checkOutput($sformatf("%s write%0d", nm, i),
                        64'((i < writes.size()) ? writes[i] : 40'h0), 64'(vecs[v].exp_wr[i]));
         end
         checkOutput({nm, " size"}, 64'(cart_size), 64'(vecs[v].exp_size));
         checkOutput({nm, " present"}, 64'(cartridge_present), 64'(vecs[v].exp_present));
         checkOutput({nm, " overflow"}, 64'(overflow), 64'(vecs[v].exp_overflow));
      end

      // Stalled SDRAM while 12 bytes stream: FIFO keeps the first four words, later ones drop.
      stim_q.delete();
      for (int b = 0; b < 12; b++) pushByte(b, 8'(8'h10 + b));
      ack_enable = 1'b0;
      stable_err = 0;
      writes.delete();
      applyStimulus(8'h01, 0);
      repeat (44) @(negedge clk_sys);
      checkOutput("stall mem_req held", 64'(mem_req), 64'd1);
      checkOutput("stall overflow", 64'(overflow), 64'd1);
      ack_enable = 1'b1;
      waitIdle("stall");
      checkOutput("stall addr/din stable", 64'(stable_err), 64'd0);
      checkOutput("stall write count", 64'(writes.size()), 64'd4);
      checkOutput("stall first write", 64'((writes.size() > 0) ? writes[0] : 40'h0), 64'h080000_1110);
      checkOutput("stall last kept write", 64'((writes.size() > 3) ? writes[3] : 40'h0), 64'h080006_1716);
      checkOutput("stall size", 64'(cart_size), 64'd12);
      checkOutput("stall overflow sticky", 64'(overflow), 64'd1);

      // Eject held across the busy fall must keep the cartridge absent.
      stim_q.delete();
      pushByte(0, 8'hA1);
      pushByte(1, 8'hB2);
      ack_delay = 1;
      applyStimulus(8'h01, 1);
      eject = 1'b1;
      waitIdle("eject race");
      eject = 1'b0;
      @(negedge clk_sys);
      checkOutput("eject race present", 64'(cartridge_present), 64'd0);
      checkOutput("eject race size", 64'(cart_size), 64'd2);
      checkOutput("eject race overflow cleared", 64'(overflow), 64'd0);

      // Reset while a request is outstanding, then a clean 2-byte load.
      stim_q.delete();
      pushByte(0, 8'h05);
      pushByte(1, 8'h06);
      ack_enable = 1'b0;
      applyStimulus(8'h01, 1);
      for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk_sys);
      checkOutput("rst req seen", 64'(mem_req), 64'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst mem_req drop", 64'(mem_req), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst present", 64'(cartridge_present), 64'd0);
      checkOutput("rst size", 64'(cart_size), 64'd0);
      @(negedge clk_sys);
      reset = 1'b0;
      ack_enable = 1'b1;
      ack_delay = 2;
      writes.delete();
      stim_q.delete();
      pushByte(0, 8'h77);
      pushByte(1, 8'h88);
      applyStimulus(8'h01, 1);
      waitIdle("post-reset");
      checkOutput("post-reset write count", 64'(writes.size()), 64'd1);
      checkOutput("post-reset write", 64'((writes.size() > 0) ? writes[0] : 40'h0), 64'h080000_8877);
      checkOutput("post-reset present", 64'(cartridge_present), 64'd1);

`ifdef MO_CART_CHECKSUM_EN
      stim_q.delete();
      pushByte(0, 8'h01);
      pushByte(1, 8'h02);
      pushByte(2, 8'hFF);
      applyStimulus(8'h01, 1);
      waitIdle("checksum");
      checkOutput("checksum value", 64'(checksum), 64'h0102);
`endif

      // Randomized sequential loads, optionally with one out-of-range byte mixed in.
      for (int it = 0; it < 20; it++) begin
         int n;
         int oor_pos;
         n = int'($urandom_range(1, 16));
         oor_pos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
         stim_q.delete();
         for (int b = 0; b <= n; b++) begin
            if (b == oor_pos) pushByte(MAX_B + int'($urandom_range(0, 255)), 8'($urandom));
            if (b < n) pushByte(b, 8'($urandom));
         end
         ack_delay = int'($urandom_range(0, 3));
         writes.delete();
         applyStimulus(8'h01 | (8'($urandom) & 8'hFE), int'($urandom_range(3, 5)));
         nm = $sformatf("rand%0d", it);
         waitIdle(nm);
         buildModel(m_size, m_ovf);
         checkOutput({nm, " write count"}, 64'(writes.size()), 64'(exp_q.size()));
         foreach (exp_q[i]) begin
            checkOutput($sformatf("%s write%0d", nm, i),
                        64'((i < writes.size()) ? writes[i] : 40'h0), 64'(exp_q[i]));
         end
         checkOutput({nm, " size"}, 64'(cart_size), 64'(m_size));
         checkOutput({nm, " present"}, 64'(cartridge_present), 64'(m_size != 17'd0));
         checkOutput({nm, " overflow"}, 64'(overflow), 64'(m_ovf));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
